// File: rtl/spi_pkg.sv
// Shared frame layout, peripheral register map and controller state encoding
// for the SPI mode-0 configuration-write path.
package spi_pkg;

    localparam int FRAME_W = 16;
    localparam int ADDR_W  = 7;
    localparam int DATA_W  = 8;
    localparam int RW_BIT  = 15;

    localparam logic [ADDR_W-1:0] REG_EN_OUT_7_0  = 7'h00;
    localparam logic [ADDR_W-1:0] REG_EN_OUT_15_8 = 7'h01;
    localparam logic [ADDR_W-1:0] REG_EN_PWM_7_0  = 7'h02;
    localparam logic [ADDR_W-1:0] REG_EN_PWM_15_8 = 7'h03;
    localparam logic [ADDR_W-1:0] REG_PWM_DUTY    = 7'h04;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        GAP
    } state_t;

    function automatic logic [FRAME_W-1:0] pack_frame(
        input logic              rw,
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] data
    );
        logic [FRAME_W-1:0] f;
        f                     = '0;
        f[RW_BIT]             = rw;
        f[RW_BIT-1 -: ADDR_W] = addr;
        f[DATA_W-1:0]         = data;
        return f;
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// SCLK half-period divider: o_phase_end strobes on the last clk of every
// CLK_DIV-cycle phase; held at zero while i_clr is high.
module spi_clk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    output logic o_phase_end
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] r_cnt;

    assign o_phase_end = (r_cnt == CW'(CLK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr || o_phase_end) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 master issuing one 16-bit {rw, addr, data} frame per start; frame
// occupies 33*CLK_DIV + GAP_CYCLES clk, done lands one cycle later, start is ignored while busy.
module spi_controller
    import spi_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              sclk,
    output logic              ncs,
    output logic              copi,
    input  logic              cipo
);

    localparam int GW = $clog2(GAP_CYCLES);

    state_t             r_state, w_state_nxt;
    logic [FRAME_W-1:0] r_shift, w_shift_nxt;
    logic [DATA_W-1:0]  r_rx, w_rx_nxt;
    logic [DATA_W-1:0]  r_rdata, w_rdata_nxt;
    logic [3:0]         r_bit, w_bit_nxt;
    logic [GW-1:0]      r_gap, w_gap_nxt;
    logic               r_sclk, w_sclk_nxt;
    logic               r_ncs, w_ncs_nxt;
    logic               r_copi, w_copi_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_done, w_done_nxt;
    logic               w_phase_end;
    logic               w_div_clr;

    assign w_div_clr = (r_state == IDLE);

    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
        .clk         (clk),
        .rst         (rst),
        .i_clr       (w_div_clr),
        .o_phase_end (w_phase_end)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_rx    <= '0;
            r_rdata <= '0;
            r_bit   <= '0;
            r_gap   <= '0;
            r_sclk  <= 1'b0;
            r_ncs   <= 1'b1;
            r_copi  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_rx    <= w_rx_nxt;
            r_rdata <= w_rdata_nxt;
            r_bit   <= w_bit_nxt;
            r_gap   <= w_gap_nxt;
            r_sclk  <= w_sclk_nxt;
            r_ncs   <= w_ncs_nxt;
            r_copi  <= w_copi_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_rx_nxt    = r_rx;
        w_rdata_nxt = r_rdata;
        w_bit_nxt   = r_bit;
        w_gap_nxt   = r_gap;
        w_sclk_nxt  = r_sclk;
        w_ncs_nxt   = r_ncs;
        w_copi_nxt  = r_copi;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_shift_nxt = pack_frame(rw, addr, wdata);
                    w_copi_nxt  = rw;
                    w_ncs_nxt   = 1'b0;
                    w_busy_nxt  = 1'b1;
                    w_bit_nxt   = '0;
                    w_state_nxt = SETUP;
                end
            end
            SETUP: begin
                if (w_phase_end) begin
                    w_sclk_nxt  = 1'b1;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (w_phase_end) begin
                    if (r_sclk) begin
                        // Falling edge: capture CIPO, and move COPI except after bit 0 (hold time).
                        w_sclk_nxt = 1'b0;
                        w_rx_nxt   = {r_rx[DATA_W-2:0], cipo};
                        if (r_bit != 4'd15) begin
                            w_shift_nxt = r_shift << 1;
                            w_copi_nxt  = r_shift[FRAME_W-2];
                        end
                    end else if (r_bit == 4'd15) begin
                        w_state_nxt = GAP;
                        w_ncs_nxt   = 1'b1;
                        w_copi_nxt  = 1'b0;
                        w_gap_nxt   = '0;
                    end else begin
                        w_bit_nxt  = r_bit + 4'd1;
                        w_sclk_nxt = 1'b1;
                    end
                end
            end
            GAP: begin
                if (r_gap == GW'(GAP_CYCLES - 1)) begin
                    w_state_nxt = IDLE;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_rdata_nxt = r_rx;
                end else begin
                    w_gap_nxt = r_gap + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign rdata = r_rdata;
    assign sclk  = r_sclk;
    assign ncs   = r_ncs;
    assign copi  = r_copi;

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: per-frame timing/content checks against frame-level
// expectations, plus a behavioural register peripheral listening on the SPI pins.
module tb_spi_controller;

    localparam int H = 4;
    localparam int G = 8;
    localparam int FRAME_CYC = 33 * H + G;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       rw = 1'b0;
    logic [6:0] addr = '0;
    logic [7:0] wdata = '0;
    logic       cipo = 1'b0;
    logic       busy, done, sclk, ncs, copi;
    logic [7:0] rdata;

    int n_pass  = 0;
    int n_total = 0;

    spi_controller #(.CLK_DIV(H), .GAP_CYCLES(G)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .rw    (rw),
        .addr  (addr),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .rdata (rdata),
        .sclk  (sclk),
        .ncs   (ncs),
        .copi  (copi),
        .cipo  (cipo)
    );

    always #5 clk = ~clk;

    // Register peripheral: commits a write only for a complete 16-edge frame with bit 15 set.
    logic [7:0]  p_regs [128] = '{default: 8'h00};
    logic [15:0] p_shift = '0;
    int          p_cnt = 0;

    always @(posedge sclk) begin
        if (ncs === 1'b0) begin
            p_shift <= {p_shift[14:0], copi};
            p_cnt   <= p_cnt + 1;
        end
    end

    always @(posedge ncs) begin
        if (p_cnt == 16 && p_shift[15] === 1'b1) p_regs[p_shift[14:8]] <= p_shift[7:0];
        p_cnt <= 0;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, observed running expected finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Entered just after a negedge; that cycle is T0. Watches the frame cycle by cycle.
    task automatic run_frame(input logic [15:0] frm, input logic [15:0] pat,
                             input bit midstart, input bit chain, input logic [15:0] nxt);
        int k, kmax, rises, first_rise, last_rise, bad_space, unstable;
        int ncs_fall, ncs_rise, busy_bad, done_cnt, done_k, sclk_cs_hi;
        logic [15:0] got;
        logic [7:0]  rd;
        logic        p_sclk, p_copi;
        start = 1'b1;
        {rw, addr, wdata} = frm;
        p_sclk = sclk; p_copi = copi; got = '0; rd = '0;
        rises = 0; first_rise = -1; last_rise = -1; bad_space = 0; unstable = 0;
        ncs_fall = -1; ncs_rise = -1; busy_bad = 0; done_cnt = 0; done_k = -1; sclk_cs_hi = 0;
        kmax = chain ? FRAME_CYC + 1 : FRAME_CYC + 3;
        for (k = 1; k <= kmax; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0;
                {rw, addr, wdata} = 16'($urandom);
            end
            if (midstart && k == 20) begin
                start = 1'b1;
                {rw, addr, wdata} = ~frm;
            end
            if (midstart && k == 21) start = 1'b0;
            if (sclk === 1'b1 && p_sclk === 1'b0) begin
                if (copi !== p_copi) unstable++;
                if (rises < 16) begin
                    got  = {got[14:0], copi};
                    cipo = pat[4'(15 - rises)];
                end
                if (first_rise < 0) first_rise = k;
                else if (k - last_rise != 2 * H) bad_space++;
                last_rise = k;
                rises++;
            end
            if (ncs === 1'b1 && sclk !== 1'b0) sclk_cs_hi++;
            if (ncs_fall < 0 && ncs === 1'b0) ncs_fall = k;
            if (ncs_fall >= 0 && ncs_rise < 0 && ncs === 1'b1) ncs_rise = k;
            if (busy !== (k <= FRAME_CYC)) busy_bad++;
            if (done !== 1'b0) begin
                done_cnt++;
                done_k = k;
                rd = rdata;
            end
            if (chain && k == kmax) begin
                start = 1'b1;
                {rw, addr, wdata} = nxt;
            end
            p_sclk = sclk;
            p_copi = copi;
        end
        check("copi_word", 32'(got), 32'(frm));
        check("rise_count", rises, 16);
        check("first_rise", first_rise, H + 1);
        check("rise_spacing_bad", bad_space, 0);
        check("copi_unstable_at_rise", unstable, 0);
        check("ncs_fall", ncs_fall, 1);
        check("ncs_rise", ncs_rise, 33 * H + 1);
        check("sclk_while_ncs_high", sclk_cs_hi, 0);
        check("busy_window_bad", busy_bad, 0);
        check("done_count", done_cnt, 1);
        check("done_cycle", done_k, FRAME_CYC + 1);
        check("rdata", 32'(rd), 32'(pat[7:0]));
    endtask

    initial begin
        logic [15:0] f1, f2;
        logic [7:0]  old;
        int          dcnt;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_sclk", 32'(sclk), 0);
        check("rst_ncs", 32'(ncs), 1);
        check("rst_copi", 32'(copi), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_rdata", 32'(rdata), 0);
        rst = 1'b0;
        @(negedge clk);

        run_frame(16'h8480, 16'h0000, 1'b0, 1'b0, 16'h0);

        run_frame(16'h80A5, 16'($urandom), 1'b0, 1'b1, 16'h843C);
        run_frame(16'h843C, 16'($urandom), 1'b0, 1'b0, 16'h0);
        check("reg00", 32'(p_regs[0]), 32'h A5);
        check("reg04", 32'(p_regs[4]), 32'h 3C);
        check("reg01", 32'(p_regs[1]), 0);
        check("reg02", 32'(p_regs[2]), 0);
        check("reg03", 32'(p_regs[3]), 0);

        run_frame(16'h01FF, 16'($urandom), 1'b0, 1'b0, 16'h0);
        check("reg01_after_read", 32'(p_regs[1]), 0);

        f1 = 16'($urandom);
        f2 = 16'($urandom);
        run_frame(f1, 16'($urandom), 1'b1, 1'b1, f2);
        run_frame(f2, 16'($urandom), 1'b0, 1'b0, 16'h0);

        run_frame(16'($urandom), 16'hFFFF, 1'b0, 1'b0, 16'h0);
        run_frame(16'($urandom), 16'h005A, 1'b0, 1'b0, 16'h0);

        for (int i = 0; i < 4; i++) begin
            run_frame(16'($urandom), 16'($urandom), 1'b0, 1'b0, 16'h0);
        end

        old = p_regs[2];
        start = 1'b1;
        {rw, addr, wdata} = 16'h8277;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
        end
        rst = 1'b1;
        #1;
        check("midrst_ncs", 32'(ncs), 1);
        check("midrst_sclk", 32'(sclk), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_copi", 32'(copi), 0);
        @(negedge clk);
        rst = 1'b0;
        dcnt = 0;
        for (int k = 0; k < FRAME_CYC; k++) begin
            @(negedge clk);
            if (done !== 1'b0) dcnt++;
        end
        check("midrst_no_done", dcnt, 0);
        check("midrst_reg_untouched", 32'(p_regs[2]), 32'(old));

        run_frame(16'h8277, 16'($urandom), 1'b0, 1'b0, 16'h0);
        check("reg02_after_reissue", 32'(p_regs[2]), 32'h77);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
